// File: rtl/div64_arb_pkg.sv
// div64_arb_pkg: shared constants for the 64-bit divider arbiter.
// Latency: n/a, constants only.
// Backpressure: n/a.
package div64_arb_pkg;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_RECV = 3'd3;
  localparam logic [2:0] ST_RESP = 3'd4;

  // Both divider channels move 64-bit pairs as four 32-bit beats
  localparam int         NUM_CHUNKS = 4;
  localparam logic [1:0] LAST_CHUNK = 2'(NUM_CHUNKS - 1);

  // Operand beat order towards the divider
  localparam logic [1:0] OP_A_LO = 2'd0;
  localparam logic [1:0] OP_A_HI = 2'd1;
  localparam logic [1:0] OP_B_LO = 2'd2;
  localparam logic [1:0] OP_B_HI = 2'd3;

  // Result beat order from the divider: remainder first, then quotient
  localparam logic [1:0] RS_R_LO = 2'd0;
  localparam logic [1:0] RS_R_HI = 2'd1;
  localparam logic [1:0] RS_Q_LO = 2'd2;
  localparam logic [1:0] RS_Q_HI = 2'd3;

  // Quotient reported for a zero divisor when the divider is bypassed
  localparam logic [63:0] BYPASS_Q = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, scanning upward from ptr and wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when a pick is taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_vld
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] idx;

  // First set request bit at or after ptr, modulo N
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = IW'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

  assign gnt_vld = found;

endmodule

// File: rtl/div64_arbiter.sv
// div64_arbiter: round-robin share of one 64-bit divider among NUM_REQ requesters; build option DIV64_ARB_ZERO_BYPASS_EN.
// Latency: done_o 10 cycles after IDLE samples req_i with no stalls, +1 per stall cycle; 2 cycles on zero-divisor bypass.
// Backpressure: operand beat held while dv_ready_i is low; result beats accepted only in RECV via dv_ready_o.
module div64_arbiter
  import div64_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int CHUNK_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ*64-1:0]  a_i,
  input  logic [NUM_REQ*64-1:0]  b_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     done_o,
  output logic [63:0]            q_o,
  output logic [63:0]            r_o,
  output logic                   busy_o,
  output logic [CHUNK_W-1:0]     dv_data_o,
  output logic                   dv_valid_o,
  input  logic                   dv_ready_i,
  input  logic [CHUNK_W-1:0]     dv_data_i,
  input  logic                   dv_valid_i,
  output logic                   dv_ready_o
);

  localparam int IW = $clog2(NUM_REQ);

  logic [2:0]         state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] gnt_r;
  logic [IW-1:0]      gnt_idx;
  logic [1:0]         cnt;
  logic [63:0]        a_lat;
  logic [63:0]        b_lat;
  logic [63:0]        r_acc;
  logic [31:0]        q_lo;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic               send_fire;
  logic               recv_fire;
  logic               last_beat;
  logic               bypass;

  logic [63:0] a_arr [NUM_REQ];
  logic [63:0] b_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k] = a_i[64*k +: 64];
    assign b_arr[k] = b_i[64*k +: 64];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req     (req_i),
    .ptr     (ptr),
    .gnt     (pick),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  assign send_fire = (state == ST_SEND) && dv_ready_i;
  assign recv_fire = (state == ST_RECV) && dv_valid_i;
  assign last_beat = (cnt == LAST_CHUNK);

`ifdef DIV64_ARB_ZERO_BYPASS_EN
  // Zero divisor never reaches the divider; answer is fixed
  assign bypass = (b_arr[gnt_idx] == 64'd0);
`else
  assign bypass = 1'b0;
`endif

  // Control FSM: grant, beat counter and round-robin pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      gnt_r   <= '0;
      gnt_idx <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_r   <= pick;
            gnt_idx <= pick_idx;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt   <= '0;
          state <= bypass ? ST_RESP : ST_SEND;
        end
        ST_SEND: begin
          if (send_fire) begin
            cnt <= cnt + 2'd1;
            if (last_beat) state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (recv_fire) begin
            cnt <= cnt + 2'd1;
            if (last_beat) state <= ST_RESP;
          end
        end
        ST_RESP: begin
          gnt_r <= '0;
          ptr   <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Datapath: operand latch, result assembly, held result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_lat <= '0;
      b_lat <= '0;
      r_acc <= '0;
      q_lo  <= '0;
      q_o   <= '0;
      r_o   <= '0;
    end else begin
      if (state == ST_LOAD) begin
        a_lat <= a_arr[gnt_idx];
        b_lat <= b_arr[gnt_idx];
        if (bypass) begin
          q_o <= BYPASS_Q;
          r_o <= a_arr[gnt_idx];
        end
      end
      if (recv_fire) begin
        case (cnt)
          RS_R_LO: r_acc[31:0]  <= dv_data_i;
          RS_R_HI: r_acc[63:32] <= dv_data_i;
          RS_Q_LO: q_lo         <= dv_data_i;
          default: begin
            // final beat: publish both results together so they only change at done
            q_o <= {dv_data_i, q_lo};
            r_o <= r_acc;
          end
        endcase
      end
    end
  end

  // Operand beat select; driven from latched registers so it holds across stalls
  always_comb begin
    dv_data_o = '0;
    if (state == ST_SEND) begin
      case (cnt)
        OP_A_LO: dv_data_o = a_lat[31:0];
        OP_A_HI: dv_data_o = a_lat[63:32];
        OP_B_LO: dv_data_o = b_lat[31:0];
        default: dv_data_o = b_lat[63:32];
      endcase
    end
  end

  assign gnt_o      = gnt_r;
  assign done_o     = (state == ST_RESP) ? gnt_r : '0;
  assign busy_o     = (state != ST_IDLE);
  assign dv_valid_o = (state == ST_SEND);
  assign dv_ready_o = (state == ST_RECV);

endmodule

// File: doc/div64_arbiter.md
# div64_arbiter

Round-robin controller that shares one 64-bit divider datapath among `NUM_REQ` requesters. It grants one requester at a time, latches that requester's 64-bit dividend and divisor, and streams them to the divider as four 32-bit chunks. It then collects four 32-bit result chunks (remainder, then quotient) and returns the 64-bit quotient and remainder with a one-cycle done pulse. It sits between the processor-facing request logic and the divider core.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CHUNK_W`, default 32: chunk width on the divider channels; fixed at 32.
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_i`  in  NUM_REQ  level request per requester; held until its `done_o` bit pulses.
- `a_i`  in  NUM_REQ*64  dividends; requester k at bits [64k+63:64k].
- `b_i`  in  NUM_REQ*64  divisors; same packing as `a_i`.
- `gnt_o`  out  NUM_REQ  one-hot grant, high for the whole transaction.
- `done_o`  out  NUM_REQ  one-cycle pulse on the granted bit when results are valid.
- `q_o`  out  64  quotient; valid while `done_o` is high, held until the next done.
- `r_o`  out  64  remainder; same validity as `q_o`.
- `busy_o`  out  1  high in every state except IDLE.
- `dv_data_o`  out  32  operand chunk to divider.
- `dv_valid_o`  out  1  operand chunk valid.
- `dv_ready_i`  in  1  divider accepts the chunk.
- `dv_data_i`  in  32  result chunk from divider.
- `dv_valid_i`  in  1  result chunk valid.
- `dv_ready_o`  out  1  arbiter accepts the result chunk.

## Operation
- States: IDLE, LOAD, SEND, RECV, RESP.
- IDLE: if any `req_i` bit is set, the round-robin pick is taken, starting from the bit after the last served requester. The pointer resets to bit 0. The chosen bit goes to LOAD.
- LOAD: `gnt_o` is asserted. `a_i`/`b_i` of the winner are latched into 64-bit registers. The 2-bit chunk counter is cleared. Next state is SEND.
- SEND: `dv_valid_o`=1. Chunk order by counter: 0 = a[31:0], 1 = a[63:32], 2 = b[31:0], 3 = b[63:32]. The counter advances only on `dv_valid_o & dv_ready_i`. After beat 3 transfers, go to RECV with the counter cleared.
- RECV: `dv_ready_o`=1. Beats on `dv_valid_i & dv_ready_o` fill, in order, r[31:0], r[63:32], q[31:0], q[63:32]. After beat 3, go to RESP.
- RESP: the `done_o` bit of the granted requester pulses. `q_o`/`r_o` present the assembled values. The round-robin pointer moves to the bit after the granted one. Next state is IDLE, and `gnt_o` clears there.
- Requester drops `req_i` mid-transaction: the transaction completes and `done_o` still pulses. Latched operands are unaffected by input changes after LOAD.
- `dv_valid_i` outside RECV is ignored, and `dv_ready_o` stays 0 there.
- A new request arriving while busy waits. A requester that has just been served loses priority to all others for the next pick.

## Timing
- Reset values: `gnt_o`, `done_o`, `busy_o`, `dv_valid_o`, `dv_ready_o` = 0; `dv_data_o`, `q_o`, `r_o` = 0; state = IDLE; pointer = 0. Reset mid-transaction aborts immediately with no done pulse.
- Cycle numbering, with zero stalls and the divider answering immediately:
  - Cycle 0: IDLE samples `req_i`.
  - Cycle 1: LOAD.
  - Cycles 2-5: SEND.
  - Cycles 6-9: RECV.
  - Cycle 10: RESP, `done_o` high.
- Each stall cycle on either channel adds one cycle.
- `dv_data_o` is stable while `dv_valid_o`=1 and `dv_ready_i`=0.
- Back-to-back requests: IDLE sits for one cycle between RESP and the next LOAD.

## Configuration
- `DIV64_ARB_ZERO_BYPASS_EN` defined: in LOAD, if the latched b == 0, the arbiter goes straight to RESP with q = 64'hFFFF_FFFF_FFFF_FFFF and r = a. No divider traffic occurs, and `done_o` pulses in cycle 2.
- Undefined: divisor 0 is sent to the divider like any other value.

## Structure
- Package `div64_arb_pkg`: state encoding constants, `NUM_CHUNKS`=4, chunk-index constants for the operand and result order, and the bypass quotient value.
- Sub-module `rr_arbiter`: combinational one-hot round-robin pick from `req` and the pointer. It is reusable for other shared engines.

## Test plan
- Single request, no stalls: requester 0, a=100, b=7 (divider model returns q=14, r=2). Expect `done_o`[0] at cycle 10, q_o=14, r_o=2, and chunk order on `dv_data_o` = 100, 0, 7, 0.
- All four requesting together from reset: grants go 0,1,2,3. Each `gnt_o` is one-hot and never overlaps, and each `done_o` carries that requester's results.
- Random `dv_ready_i`/`dv_valid_i` stalls with a=64'h1_0000_0000, b=3: `dv_data_o` holds during stalls, and the result is q=0x55555555, r=1.
- Requester 1 drops `req_i` after LOAD while requester 2 is pending: `done_o`[1] still pulses, then requester 2 is granted.
- `reset_n` asserted during RECV: all outputs are 0 immediately, no done pulse, and the next request is served from pointer 0.
- With `DIV64_ARB_ZERO_BYPASS_EN`, b=0, a=5: q_o is all ones, r_o=5, `done_o` pulses at cycle 2, and `dv_valid_o` never rises.
